// File: rtl/trig_record_fifo.sv
// Circular FIFO of trigger records {mask, timestamp} served as 32-bit words over a request/valid frame.
// Optional TRIG_RECORD_SEQNUM_EN adds a per-record sequence number and a third frame word.
module trig_record_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int TS_W       = 56
) (
  input  logic                  clk_adc,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  trig_valid,
  input  logic [7:0]            trig_bits,
  input  logic [TS_W-1:0]       timestamp,
  input  logic                  rd_req,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic                  rd_nodata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic [15:0]           overflow_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
`ifdef TRIG_RECORD_SEQNUM_EN
  localparam int REC_W = 16 + 8 + TS_W;
  typedef enum logic [1:0] {S_IDLE, S_W0, S_W1, S_W2} state_t;
`else
  localparam int REC_W = 8 + TS_W;
  typedef enum logic [1:0] {S_IDLE, S_W0, S_W1} state_t;
`endif

  state_t                  state_q, state_d;
  logic [REC_W-1:0]        mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    empty_q, full_q;
  logic [15:0]             ovf_q, ovf_d;
  logic [31:0]             rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_nodata_q, rd_nodata_d;
  logic [31:0]             frame_ts_lo_q;
  logic                    flush, push, pop, load_frame;
  logic [REC_W-1:0]        rd_rec, wr_rec;
  logic [23:0]             ts_hi;
`ifdef TRIG_RECORD_SEQNUM_EN
  logic [15:0]             seq_q;
  logic [15:0]             frame_seq_q;
`endif

  assign flush  = reset | clear;
  assign push   = trig_valid & ~full_q;
  assign rd_rec = mem_q[rd_ptr_q];

`ifdef TRIG_RECORD_SEQNUM_EN
  assign wr_rec = {seq_q, trig_bits, timestamp};
`else
  assign wr_rec = {trig_bits, timestamp};
`endif

  always_comb begin
    ts_hi = '0;
    ts_hi[TS_W-33:0] = rd_rec[TS_W-1:32];
  end

  // Full is judged on the start-of-cycle count, so a push racing a pop from full is dropped.
  always_comb begin
    ovf_d = ovf_q;
    if (trig_valid && full_q && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{DEPTH_LOG2{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rd_data_d   = '0;
    rd_valid_d  = 1'b0;
    rd_nodata_d = 1'b0;
    pop         = 1'b0;
    load_frame  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          if (!empty_q) begin
            state_d    = S_W0;
            rd_valid_d = 1'b1;
            rd_data_d  = {rd_rec[TS_W+7:TS_W], ts_hi};
            load_frame = 1'b1;
          end else begin
            rd_nodata_d = 1'b1;
          end
        end
      end
      S_W0: begin
        state_d    = S_W1;
        rd_valid_d = 1'b1;
        rd_data_d  = frame_ts_lo_q;
      end
`ifdef TRIG_RECORD_SEQNUM_EN
      S_W1: begin
        state_d    = S_W2;
        rd_valid_d = 1'b1;
        rd_data_d  = {frame_seq_q, ovf_d};
      end
      S_W2: begin
        state_d = S_IDLE;
        pop     = 1'b1;
      end
`else
      S_W1: begin
        state_d = S_IDLE;
        pop     = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_adc) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_rec;
  end

  always_ff @(posedge clk_adc) begin
    if (flush) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      ovf_q         <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_nodata_q   <= 1'b0;
      frame_ts_lo_q <= '0;
`ifdef TRIG_RECORD_SEQNUM_EN
      seq_q         <= '0;
      frame_seq_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      empty_q     <= (count_d == '0);
      full_q      <= (count_d == FULL_CNT);
      ovf_q       <= ovf_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_nodata_q <= rd_nodata_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (load_frame) frame_ts_lo_q <= rd_rec[31:0];
`ifdef TRIG_RECORD_SEQNUM_EN
      if (push) seq_q <= seq_q + 16'd1;
      if (load_frame) frame_seq_q <= rd_rec[REC_W-1 -: 16];
`endif
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign rd_nodata    = rd_nodata_q;
  assign count        = count_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_trig_record_fifo.sv
// Directed bench for trig_record_fifo: per-cycle vector table plus hand-written fill/drop/clear sequences.
module tb_trig_record_fifo;

  logic        clk_adc = 1'b0;
  logic        reset, clear, trig_valid, rd_req;
  logic [7:0]  trig_bits;
  logic [55:0] timestamp;
  logic [31:0] rd_data;
  logic        rd_valid, rd_nodata, empty, full;
  logic [3:0]  count;
  logic [15:0] overflow_cnt;

  int checks = 0;
  int errors = 0;

  trig_record_fifo #(.DEPTH_LOG2(3), .TS_W(56)) dut (
    .clk_adc(clk_adc), .reset(reset), .clear(clear), .trig_valid(trig_valid),
    .trig_bits(trig_bits), .timestamp(timestamp), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_nodata(rd_nodata),
    .count(count), .empty(empty), .full(full), .overflow_cnt(overflow_cnt)
  );

  always #5 clk_adc = ~clk_adc;

  typedef struct {
    logic        tv;
    logic [7:0]  tb;
    logic [55:0] ts;
    logic        rq;
    logic        ev;
    logic [31:0] ed;
    logic        en;
    logic [3:0]  ec;
    logic        ee;
    logic        ef;
    logic [15:0] eo;
  } vec_t;

  vec_t vecs [13];

  task automatic cyc();
    @(negedge clk_adc);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] rec_ts(input int i);
    return {8'h00, 16'hA000 + 16'(i), 32'hC0DE0000 + 32'(i)};
  endfunction

  function automatic logic [7:0] rec_bits(input int i);
    return 8'h10 + 8'(i);
  endfunction

  task automatic push(input int i);
    trig_valid = 1'b1;
    trig_bits  = rec_bits(i);
    timestamp  = rec_ts(i);
    cyc();
    trig_valid = 1'b0;
  endtask

  task automatic read_frame(output logic [31:0] w0, output logic [31:0] w1,
                            output logic [31:0] w2, output logic ok);
    ok = 1'b1;
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    ok &= rd_valid;
    w0 = rd_data;
    cyc();
    ok &= rd_valid;
    w1 = rd_data;
`ifdef TRIG_RECORD_SEQNUM_EN
    cyc();
    ok &= rd_valid;
    w2 = rd_data;
`else
    w2 = '0;
`endif
    cyc();
    ok &= ~rd_valid;
  endtask

  task automatic check_rec(input string name, input int i);
    logic [31:0] w0, w1, w2;
    logic ok;
    read_frame(w0, w1, w2, ok);
    check(name, {31'd0, ok, w0, w1}, {31'd0, 1'b1, rec_bits(i), 8'h00, 16'hA000 + 16'(i), 32'hC0DE0000 + 32'(i)});
  endtask

  function automatic vec_t mk(input logic tv, input logic [7:0] tb, input logic [55:0] ts, input logic rq,
                              input logic ev, input logic [31:0] ed, input logic en, input logic [3:0] ec,
                              input logic ee, input logic ef, input logic [15:0] eo);
    vec_t v;
    v.tv = tv; v.tb = tb; v.ts = ts; v.rq = rq;
    v.ev = ev; v.ed = ed; v.en = en; v.ec = ec; v.ee = ee; v.ef = ef; v.eo = eo;
    return v;
  endfunction

  initial begin
    logic [31:0] w0, w1, w2;
    logic ok;

    vecs[0]  = mk(1, 8'h05, 56'h00_1234_5678_9ABC, 0,  0, 32'h0,        0, 4'd1, 0, 0, 16'd0);
    vecs[1]  = mk(0, 8'h00, 56'h0,                 1,  1, 32'h05001234, 0, 4'd1, 0, 0, 16'd0);
    vecs[2]  = mk(0, 8'h00, 56'h0,                 0,  1, 32'h56789ABC, 0, 4'd1, 0, 0, 16'd0);
    vecs[3]  = mk(0, 8'h00, 56'h0,                 0,  0, 32'h0,        0, 4'd0, 1, 0, 16'd0);
    vecs[4]  = mk(0, 8'h00, 56'h0,                 1,  0, 32'h0,        1, 4'd0, 1, 0, 16'd0);
    vecs[5]  = mk(0, 8'h00, 56'h0,                 0,  0, 32'h0,        0, 4'd0, 1, 0, 16'd0);
    vecs[6]  = mk(1, 8'h00, 56'hAB_CDEF_0123_4567, 0,  0, 32'h0,        0, 4'd1, 0, 0, 16'd0);
    vecs[7]  = mk(0, 8'h00, 56'h0,                 1,  1, 32'h00ABCDEF, 0, 4'd1, 0, 0, 16'd0);
    vecs[8]  = mk(1, 8'h3C, 56'h11_2222_3333_4444, 1,  1, 32'h01234567, 0, 4'd2, 0, 0, 16'd0);
    vecs[9]  = mk(0, 8'h00, 56'h0,                 0,  0, 32'h0,        0, 4'd1, 0, 0, 16'd0);
    vecs[10] = mk(0, 8'h00, 56'h0,                 1,  1, 32'h3C112222, 0, 4'd1, 0, 0, 16'd0);
    vecs[11] = mk(0, 8'h00, 56'h0,                 0,  1, 32'h33334444, 0, 4'd1, 0, 0, 16'd0);
    vecs[12] = mk(0, 8'h00, 56'h0,                 0,  0, 32'h0,        0, 4'd0, 1, 0, 16'd0);

    reset = 1'b1; clear = 1'b0; trig_valid = 1'b0; rd_req = 1'b0;
    trig_bits = '0; timestamp = '0;
    cyc();
    cyc();
    reset = 1'b0;
    check("reset_state", {rd_valid, rd_data, rd_nodata, count, empty, full, overflow_cnt},
          {1'b0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0, 16'd0});

`ifndef TRIG_RECORD_SEQNUM_EN
    for (int i = 0; i < 13; i++) begin
      trig_valid = vecs[i].tv; trig_bits = vecs[i].tb; timestamp = vecs[i].ts; rd_req = vecs[i].rq;
      cyc();
      check($sformatf("vec%0d", i), {rd_valid, rd_data, rd_nodata, count, empty, full, overflow_cnt},
            {vecs[i].ev, vecs[i].ed, vecs[i].en, vecs[i].ec, vecs[i].ee, vecs[i].ef, vecs[i].eo});
    end
    trig_valid = 1'b0; rd_req = 1'b0;
`else
    for (int i = 0; i < 3; i++) push(i);
    for (int i = 0; i < 3; i++) begin
      read_frame(w0, w1, w2, ok);
      check($sformatf("seq_frame%0d", i), {31'd0, ok, w0, w1, w2},
            {31'd0, 1'b1, rec_bits(i), 8'h00, 16'hA000 + 16'(i), 32'hC0DE0000 + 32'(i), 16'(i), 16'h0000});
    end
    check("seq_empty", {60'd0, count}, 64'd0);
`endif

    // Nine pushes into depth 8: the ninth is dropped and counted
    for (int i = 0; i < 9; i++) push(i);
    check("fill9_flags", {count, full, empty, overflow_cnt}, {4'd8, 1'b1, 1'b0, 16'd1});
    for (int i = 0; i < 8; i++) check_rec($sformatf("fill9_rd%0d", i), i);
    check("fill9_drained", {count, empty, full}, {4'd0, 1'b1, 1'b0});

    // Push racing the final-word pop of a full FIFO
    for (int i = 20; i < 28; i++) push(i);
    check("refill_full", {count, full}, {4'd8, 1'b1});
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    check("race_w0", {rd_valid, rd_data}, {1'b1, rec_bits(20), 8'h00, 16'hA000 + 16'd20});
    cyc();
`ifdef TRIG_RECORD_SEQNUM_EN
    cyc();
`endif
    check("race_last", {31'd0, rd_valid}, {31'd0, 1'b1});
    trig_valid = 1'b1; trig_bits = 8'hEE; timestamp = 56'hFF_FFFF_FFFF_FFFF;
    cyc();
    trig_valid = 1'b0;
    check("race_drop", {rd_valid, count, full, overflow_cnt}, {1'b0, 4'd7, 1'b0, 16'd2});
    check_rec("race_next", 21);

    // Clear during W0 aborts the frame and flushes everything
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    check("clr_w0", {31'd0, rd_valid}, {31'd0, 1'b1});
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clr_state", {rd_valid, rd_nodata, count, empty, full, overflow_cnt},
          {1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 16'd0});
    push(40);
    check("clr_push", {count, empty}, {4'd1, 1'b0});
    check_rec("clr_read", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
